alu_result_stage: RTL and testbench

- Downstream stage of the combinational 4-function ALU (add, OR-reduce, AND-reduce, concatenate).
- Captures each valid ALUout into a small show-ahead FIFO and offers it to the display/consumer with a valid/ready handshake.
- Holds the most recently accepted result and feeds its low N bits back as the ALU's B operand, which gives accumulator-style chaining.

---
 rtl/alu_pkg.sv | 15 +
 rtl/result_fifo.sv | 56 +++++
 rtl/alu_result_stage.sv | 80 ++++++++
 tb/tb_alu_result_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-function ALU and its result stage.
package alu_pkg;

    localparam int ALU_N = 4;

    typedef enum logic [1:0] {
        FN_ADD = 2'b00,
        FN_OR  = 2'b01,
        FN_AND = 2'b10,
        FN_CAT = 2'b11
    } alu_fn_e;

    typedef logic [2*ALU_N-1:0] result_t;

endpackage

// File: rtl/result_fifo.sv
// Show-ahead FIFO holding ALU results: memory, read/write pointers and occupancy level.
module result_fifo
    import alu_pkg::*;
#(
    parameter int N     = ALU_N,
    parameter int DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [2*N-1:0]             wdata_i,
    output logic [2*N-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [2*N-1:0] mem_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]  level_q, level_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        // DEPTH is a power of 2, so pointer wrap is plain overflow
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_i && !pop_i)      level_d = level_q + LW'(1);
        else if (pop_i && !push_i) level_d = level_q - LW'(1);
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is left unreset; level=0 masks stale contents.
    always_ff @(posedge Clock) begin
        if (push_i && Resetn) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign level_o = level_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers results, offers them via valid/ready, feeds back last result.
// Optional accept counter enabled by defining ALU_RESULT_COUNT_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N     = ALU_N,
    parameter int DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic [2*N-1:0]             ALUout,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [2*N-1:0]             out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef ALU_RESULT_COUNT_EN
    output logic [7:0]                 accept_count,
`endif
    output logic [2*N-1:0]             last_result,
    output logic [N-1:0]               feedback_B,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic           push, pop;
    logic [LW-1:0]  level_w;
    logic [2*N-1:0] last_result_q, last_result_d;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (level_w != LW'(DEPTH));
    assign out_valid = (level_w != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    result_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (ALUout),
        .rdata_o (out_data),
        .level_o (level_w)
    );

    always_comb begin
        last_result_d = last_result_q;
        if (push) last_result_d = ALUout;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) last_result_q <= '0;
        else         last_result_q <= last_result_d;
    end

    assign last_result = last_result_q;
    assign feedback_B  = last_result_q[N-1:0];
    assign level       = level_w;

`ifdef ALU_RESULT_COUNT_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push) count_d = count_q + 8'd1;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) count_q <= '0;
        else         count_q <= count_d;
    end

    assign accept_count = count_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed testbench for alu_result_stage (works with or without ALU_RESULT_COUNT_EN).
module tb_alu_result_stage;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic           Clock = 1'b0;
    logic           Resetn;
    logic [2*N-1:0] ALUout;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] last_result;
    logic [N-1:0]   feedback_B;
    logic [2:0]     level;
`ifdef ALU_RESULT_COUNT_EN
    logic [7:0]     accept_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clock = ~Clock;

    alu_result_stage #(.N(N), .DEPTH(DEPTH)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .ALUout      (ALUout),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef ALU_RESULT_COUNT_EN
        .accept_count(accept_count),
`endif
        .last_result (last_result),
        .feedback_B  (feedback_B),
        .level       (level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    logic [7:0] fill_vec [4] = '{8'h01, 8'h00, 8'h57, 8'h0C};
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;

    initial begin
        Resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ALUout = '0;
        step(); step();
        Resetn = 1'b1;
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_feedback_B", 32'(feedback_B), 32'h0);
        check("rst_last_result", 32'(last_result), 32'h00);
`ifdef ALU_RESULT_COUNT_EN
        check("rst_accept_count", 32'(accept_count), 32'd0);
`endif

        // single push of 5+7
        in_valid = 1'b1; ALUout = 8'h0C;
        step();
        in_valid = 1'b0;
        check("p1_out_valid", 32'(out_valid), 32'd1);
        check("p1_out_data", 32'(out_data), 32'h0C);
        check("p1_level", 32'(level), 32'd1);
        check("p1_last_result", 32'(last_result), 32'h0C);
        check("p1_feedback_B", 32'(feedback_B), 32'hC);

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("p1_drain_level", 32'(level), 32'd0);
        check("p1_drain_valid", 32'(out_valid), 32'd0);

        // fill to full, then an ignored push
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; ALUout = fill_vec[i];
            step();
        end
        check("full_level", 32'(level), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        ALUout = 8'hFF;
        step();
        in_valid = 1'b0;
        check("full_ignored_level", 32'(level), 32'd4);
        check("full_ignored_last", 32'(last_result), 32'h0C);
        check("full_head", 32'(out_data), 32'h01);

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_data%0d", i), 32'(out_data), 32'(fill_vec[i]));
            check($sformatf("drain_valid%0d", i), 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b0;
        check("drain_empty_valid", 32'(out_valid), 32'd0);
        check("drain_empty_level", 32'(level), 32'd0);
        check("drain_empty_data", 32'(out_data), 32'h00);

        // empty: out_ready ignored
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("empty_pop_level", 32'(level), 32'd0);

        // level 2, then 6 cycles of simultaneous push+pop across pointer wrap
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; ALUout = 8'hA1 + 8'(i);
            exp_q.push_back(8'hA1 + 8'(i));
            step();
        end
        check("sim_pre_level", 32'(level), 32'd2);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; ALUout = 8'hB0 + 8'(i);
            exp_v = exp_q.pop_front();
            exp_q.push_back(8'hB0 + 8'(i));
            check($sformatf("sim_data%0d", i), 32'(out_data), 32'(exp_v));
            step();
            check($sformatf("sim_level%0d", i), 32'(level), 32'd2);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("sim_head", 32'(out_data), 32'hB4);
        check("sim_last", 32'(last_result), 32'hB5);

        // level 3, then reset with push and pop pending
        in_valid = 1'b1; ALUout = 8'hC0;
        step();
        check("prerst_level", 32'(level), 32'd3);
        Resetn = 1'b0; in_valid = 1'b1; out_ready = 1'b1; ALUout = 8'hEE;
        step();
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_last", 32'(last_result), 32'h00);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        Resetn = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();
        check("postrst_level", 32'(level), 32'd0);
        check("postrst_out_data", 32'(out_data), 32'h00);
        check("postrst_fb", 32'(feedback_B), 32'h0);

        // 257 accepted pushes with continuous pop
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            ALUout = 8'(i + 3);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("stream_level", 32'(level), 32'd1);
        check("stream_last", 32'(last_result), 32'h03);
        check("stream_head", 32'(out_data), 32'h03);
        check("stream_fb", 32'(feedback_B), 32'h3);
`ifdef ALU_RESULT_COUNT_EN
        check("stream_accept_count", 32'(accept_count), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
